// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and divide on one shared shift datapath.
// Define MULDIV_RADIX4_MULT_EN to retire two multiplier bits per edge for multiplies.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   typedef enum logic [1:0] {IDLE, RUN, FIN} stateType;
   stateType state, nextState;
   logic [2*WIDTH-1:0] accReg, accMul, accDiv, fixed;
   logic [WIDTH-1:0] xReg, absA, absB, rem, quot;
   logic [CNT_W-1:0] cnt, cntStep;
   logic [WIDTH:0] remShift, diff;
   logic isSigned, divReg, negHi, negLo, zeroDiv, geq;
   assign isSigned = ~op[0];
   assign absA = (isSigned && a[WIDTH-1]) ? -a : a;
   assign absB = (isSigned && b[WIDTH-1]) ? -b : b;
   // accumulator holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
`ifdef MULDIV_RADIX4_MULT_EN
   localparam logic [CNT_W-1:0] MSTEP = CNT_W'(2);
   logic [WIDTH+1:0] mulSum;
   assign mulSum = {2'b0, accReg[2*WIDTH-1:WIDTH]} + (accReg[0] ? {2'b0, xReg} : '0)
                 + (accReg[1] ? {1'b0, xReg, 1'b0} : '0);
   assign accMul = {mulSum, accReg[WIDTH-1:2]};
`else
   localparam logic [CNT_W-1:0] MSTEP = CNT_W'(1);
   logic [WIDTH:0] mulSum;
   assign mulSum = {1'b0, accReg[2*WIDTH-1:WIDTH]} + (accReg[0] ? {1'b0, xReg} : '0);
   assign accMul = {mulSum, accReg[WIDTH-1:1]};
`endif
   assign remShift = {accReg[2*WIDTH-1:WIDTH], accReg[WIDTH-1]};
   assign diff = remShift - {1'b0, xReg};
   // the remainder stays below the divisor, so a clear top bit means the trial subtract fits
   assign geq = ~diff[WIDTH];
   assign accDiv = {geq ? diff[WIDTH-1:0] : remShift[WIDTH-1:0], accReg[WIDTH-2:0], geq};
   assign cntStep = divReg ? CNT_W'(1) : MSTEP;
   assign rem = accReg[2*WIDTH-1:WIDTH];
   assign quot = accReg[WIDTH-1:0];
   assign fixed = divReg ? {negHi ? -rem : rem, negLo ? -quot : quot} : (negHi ? -accReg : accReg);
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= nextState;
   always_comb begin
      nextState = state;
      if (state == IDLE && start) nextState = (op[1] && b == '0) ? FIN : RUN;
      else if (state == RUN && cnt == cntStep) nextState = FIN;
      else if (state == FIN) nextState = IDLE;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         accReg <= '0;
         xReg <= '0;
         cnt <= '0;
         divReg <= 1'b0;
         negHi <= 1'b0;
         negLo <= 1'b0;
         zeroDiv <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         div0 <= 1'b0;
         hi <= '0;
         lo <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) begin
            accReg <= {{WIDTH{1'b0}}, absA};
            xReg <= absB;
            cnt <= CNT_W'(WIDTH);
            divReg <= op[1];
            negHi <= isSigned && (a[WIDTH-1] ^ (~op[1] & b[WIDTH-1]));
            negLo <= isSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
            zeroDiv <= op[1] && b == '0;
            busy <= 1'b1;
            div0 <= 1'b0;
         end else if (state == RUN) begin
            accReg <= divReg ? accDiv : accMul;
            cnt <= cnt - cntStep;
         end else if (state == FIN) begin
            busy <= 1'b0;
            done <= 1'b1;
            div0 <= zeroDiv;
            if (!zeroDiv) {hi, lo} <= fixed;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;
   localparam int W = 32;
`ifdef MULDIV_RADIX4_MULT_EN
   localparam int MUL_LAT = W / 2 + 1;
`else
   localparam int MUL_LAT = W + 1;
`endif
   logic clk = 0, reset = 1, start = 0;
   logic [1:0] op = 0;
   logic [W-1:0] a = 0, b = 0;
   logic busy, done, div0;
   logic [W-1:0] hi, lo;
   logic [W-1:0] curHi = 0, curLo = 0;
   int total = 0, bad = 0;
   muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy;
      logic [63:0] ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      case (o)
         2'd0: return sx * sy;
         2'd1: return ux * uy;
         2'd2: return {32'(sx % sy), 32'(sx / sy)};
         default: return {32'(ux % uy), 32'(ux / uy)};
      endcase
   endfunction
   task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit poke = 0);
      int n, lat;
      logic [63:0] exp;
      bit zero, busyOk;
      zero = o[1] && y == 0;
      exp = zero ? {curHi, curLo} : model(o, x, y);
      lat = zero ? 1 : (o[1] ? W + 1 : MUL_LAT);
      @(negedge clk);
      start = 1; op = o; a = x; b = y;
      @(posedge clk);
      #1 start = 0;
      busyOk = busy && !done;
      check({tag, " div0 clr"}, div0, 1'b0);
      n = 0;
      while (n < 60) begin
         @(posedge clk);
         #1 n++;
         if (poke && n == 5) begin
            start = 1; op = 2'b10; a = 32'h5; b = 32'h0;
         end else start = 0;
         if (done) break;
         if (!busy) busyOk = 0;
      end
      start = 0;
      check({tag, " latency"}, n, lat);
      check({tag, " busy"}, {busyOk, busy}, 2'b10);
      check({tag, " result"}, {hi, lo}, exp);
      check({tag, " div0"}, div0, zero);
      curHi = exp[63:32];
      curLo = exp[31:0];
   endtask
   initial begin
      #2 reset = 0;
      #10 check("reset state", {busy, done, div0, hi, lo}, '0);
      @(negedge clk) reset = 1;
      runOp("multu max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      check("multu max const", {hi, lo}, 64'hFFFFFFFE_00000001);
      runOp("mult -3*5", 2'd0, 32'hFFFFFFFD, 32'd5);
      check("mult -3*5 const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
      runOp("div -7/2", 2'd2, 32'hFFFFFFF9, 32'd2);
      check("div -7/2 const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      runOp("div ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF);
      check("div ovf const", {hi, lo}, 64'h00000000_80000000);
      runOp("divu 7/2", 2'd3, 32'd7, 32'd2);
      check("divu 7/2 const", {hi, lo}, 64'h00000001_00000003);
      runOp("div by zero", 2'd2, 32'd5, 32'd0);
      check("div0 keeps hilo", {hi, lo}, 64'h00000001_00000003);
      repeat (3) @(negedge clk);
      check("div0 held", div0, 1'b1);
      runOp("multu poked", 2'd1, 32'h0012D687, 32'h89ABCDEF, 1);
      @(negedge clk);
      start = 1; op = 2'd1; a = 32'h12345678; b = 32'h9ABCDEF0;
      @(posedge clk);
      #1 start = 0;
      repeat (10) @(posedge clk);
      @(negedge clk) reset = 0;
      #1 check("async reset", {busy, done, div0, hi, lo}, '0);
      curHi = 0;
      curLo = 0;
      @(negedge clk) reset = 1;
      runOp("multu 6*7", 2'd1, 32'd6, 32'd7);
      check("multu 6*7 const", {hi, lo}, 64'd42);
      for (int i = 0; i < 40; i++)
         runOp("random", 2'($urandom_range(0, 3)), (i % 5 == 0) ? 32'h80000000 : $urandom,
               ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 31));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
